// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: BCD time word, lap buffer state encoding and defaults.
package stopwatch_pkg;

  // Eight packed BCD digits, most significant (tens of hours) first.
  typedef struct packed {
    logic [3:0] hour1;
    logic [3:0] hour0;
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] seg1;
    logic [3:0] seg0;
    logic [3:0] cseg1;
    logic [3:0] cseg0;
  } bcd_time_t;

  typedef enum logic [1:0] {
    LIVE   = 2'd0,
    HOLD   = 2'd1,
    RECALL = 2'd2
  } lap_state_e;

  // 8 ticks of 250 ms keep a split on the display for 2 s.
  localparam int HOLD_TICKS_DEFAULT = 8;

  // Width of the lap counter and lap index registers (holds 0..16).
  localparam int LAP_W = 5;

endpackage

// File: rtl/lap_mem.sv
// Lap storage: DEPTH x 32-bit register file, one write port and one
// combinational read port. Addresses are generated by lap_buffer.
module lap_mem
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  bcd_time_t     wr_data,
  input  logic [AW-1:0] rd_addr,
  output bcd_time_t     rd_data
);

  bcd_time_t mem [DEPTH];

  // Store one lap per write strobe.
  // NOTE: the array has no reset; validity is tracked by the count in
  // lap_buffer, so stale entries are never shown and clear is instant.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lap_buffer.sv
// Split-time capture and recall stage between the BCD time counter and the
// display path. Captures the live time on each split, holds it on display for
// HOLD_TICKS ticks and lets the user step back through stored laps.
// Build option: define LAP_BUFFER_OVERWRITE_EN to let a capture into a full
// buffer overwrite the oldest lap; by default such a capture is refused.
module lap_buffer
  import stopwatch_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int HOLD_TICKS = HOLD_TICKS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_i,
  input  logic        capture_i,
  input  logic        recall_i,
  input  logic        clear_i,
  input  logic [31:0] time_i,
  output logic [31:0] time_o,
  output logic [3:0]  lap_idx_o,
  output logic [4:0]  count_o,
  output logic        live_o,
  output logic        full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic [LAP_W-1:0] DEPTH_L = LAP_W'(DEPTH);
  localparam logic [HW-1:0]    HOLD_L  = HW'(HOLD_TICKS);

  lap_state_e        state, nxt_state;
  logic [AW-1:0]     wp, nxt_wp;
  logic [LAP_W-1:0]  count, nxt_count;
  logic [LAP_W-1:0]  lap, nxt_lap;
  logic [HW-1:0]     hold_cnt, nxt_hold;
  bcd_time_t         time_q;
  logic              live_q, full_q;

  logic              full, capture_ok, do_write;
  logic [AW-1:0]     rd_addr;
  bcd_time_t         rd_data;

  assign full = (count == DEPTH_L);

`ifdef LAP_BUFFER_OVERWRITE_EN
  // A full buffer accepts the capture and drops its oldest lap.
  assign capture_ok = 1'b1;
`else
  // A full buffer refuses the capture; the newest stored lap is shown instead.
  assign capture_ok = !full;
`endif

  // Next-state decode; clear beats capture beats recall.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    nxt_state = state;
    nxt_wp    = wp;
    nxt_count = count;
    nxt_lap   = lap;
    nxt_hold  = hold_cnt;
    do_write  = 1'b0;
    if (clear_i) begin
      nxt_state = LIVE;
      nxt_wp    = '0;
      nxt_count = '0;
      nxt_lap   = '0;
      nxt_hold  = '0;
    end else if (capture_i) begin
      do_write  = capture_ok;
      if (capture_ok) begin
        nxt_wp = wp + AW'(1);
        if (!full) nxt_count = count + LAP_W'(1);
      end
      nxt_state = HOLD;
      nxt_lap   = LAP_W'(1);
      nxt_hold  = HOLD_L;   // a same-cycle tick is ignored by the reload
    end else begin
      case (state)
        LIVE: begin
          if (recall_i && count != '0) begin
            nxt_state = RECALL;
            nxt_lap   = LAP_W'(1);
            nxt_hold  = HOLD_L;
          end
        end
        HOLD, RECALL: begin
          if (recall_i) begin
            // From HOLD lap 1 is already on display, so step straight to 2.
            if (state == HOLD) begin
              nxt_state = RECALL;
              nxt_lap   = (count >= LAP_W'(2)) ? LAP_W'(2) : LAP_W'(1);
              nxt_hold  = HOLD_L;
            end else if (lap >= count) begin
              nxt_state = LIVE;
              nxt_lap   = '0;
              nxt_hold  = '0;
            end else begin
              nxt_lap  = lap + LAP_W'(1);
              nxt_hold = HOLD_L;
            end
          end else if (tick_i) begin
            if (hold_cnt <= HW'(1)) begin
              nxt_state = LIVE;
              nxt_lap   = '0;
              nxt_hold  = '0;
            end else begin
              nxt_hold = hold_cnt - HW'(1);
            end
          end
        end
        default: begin
          nxt_state = LIVE;
          nxt_lap   = '0;
          nxt_hold  = '0;
        end
      endcase
    end
  end

  // Lap k sits k entries behind the write pointer; look up the lap that will
  // be shown after this edge so time_o can be registered.
  assign rd_addr = nxt_wp - nxt_lap[AW-1:0];

  lap_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we      (do_write && !rst),
    .wr_addr (wp),
    .wr_data (bcd_time_t'(time_i)),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // State and registered outputs; a fresh write bypasses the array.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LIVE;
      wp       <= '0;
      count    <= '0;
      lap      <= '0;
      hold_cnt <= '0;
      time_q   <= '0;
      live_q   <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      state    <= nxt_state;
      wp       <= nxt_wp;
      count    <= nxt_count;
      lap      <= nxt_lap;
      hold_cnt <= nxt_hold;
      live_q   <= (nxt_state == LIVE);
      full_q   <= (nxt_count == DEPTH_L);
      if (nxt_state == LIVE || do_write) time_q <= bcd_time_t'(time_i);
      else                               time_q <= rd_data;
    end
  end

  assign time_o    = time_q;
  assign lap_idx_o = lap[3:0];
  assign count_o   = count;
  assign live_o    = live_q;
  assign full_o    = full_q;

endmodule

// File: tb/tb_lap_buffer.sv
// Directed self-checking bench for lap_buffer (DEPTH=8, HOLD_TICKS=8).
module tb_lap_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_i, capture_i, recall_i, clear_i;
  logic [31:0] time_i;
  logic [31:0] time_o;
  logic [3:0]  lap_idx_o;
  logic [4:0]  count_o;
  logic        live_o, full_o;

  int n_cmp = 0;
  int n_err = 0;

  lap_buffer #(.DEPTH(8), .HOLD_TICKS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_i    (tick_i),
    .capture_i (capture_i),
    .recall_i  (recall_i),
    .clear_i   (clear_i),
    .time_i    (time_i),
    .time_o    (time_o),
    .lap_idx_o (lap_idx_o),
    .count_o   (count_o),
    .live_o    (live_o),
    .full_o    (full_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_i = 1'b1; cyc();
      tick_i = 1'b0; cyc();
    end
  endtask

  task automatic capture(input logic [31:0] t);
    time_i = t; capture_i = 1'b1; cyc(); capture_i = 1'b0;
  endtask

  task automatic recall();
    recall_i = 1'b1; cyc(); recall_i = 1'b0;
  endtask

  logic [31:0] exp_newest, exp_oldest;

  initial begin
    rst = 1'b1; tick_i = 1'b0; capture_i = 1'b0; recall_i = 1'b0;
    clear_i = 1'b0; time_i = 32'h0;
    cyc(); cyc();
    check("rst_time",  time_o, 32'h0);
    check("rst_lap",   32'(lap_idx_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_live",  32'(live_o), 32'd1);
    check("rst_full",  32'(full_o), 32'd0);
    rst = 1'b0;

    // Live pass-through, one cycle late.
    time_i = 32'h00012345; cyc();
    check("live_time",  time_o, 32'h00012345);
    check("live_flag",  32'(live_o), 32'd1);
    check("live_count", 32'(count_o), 32'd0);

    // Single split and hold; recapture with a coincident tick reloads.
    capture(32'h00001050);
    check("cap_time",  time_o, 32'h00001050);
    check("cap_lap",   32'(lap_idx_o), 32'd1);
    check("cap_count", 32'(count_o), 32'd1);
    check("cap_live",  32'(live_o), 32'd0);
    time_i = 32'h00001051;
    ticks(3);
    check("hold_mid_time", time_o, 32'h00001050);
    time_i = 32'h00001052; capture_i = 1'b1; tick_i = 1'b1; cyc();
    capture_i = 1'b0; tick_i = 1'b0;
    check("recap_time",  time_o, 32'h00001052);
    check("recap_count", 32'(count_o), 32'd2);
    ticks(7);
    check("hold7_live", 32'(live_o), 32'd0);
    ticks(1);
    check("hold8_live", 32'(live_o), 32'd1);
    check("hold8_lap",  32'(lap_idx_o), 32'd0);
    check("hold8_time", time_o, 32'h00001052);

    // Clear, then three laps recalled from live.
    clear_i = 1'b1; cyc(); clear_i = 1'b0;
    check("clr_count", 32'(count_o), 32'd0);
    capture(32'h00000101); cyc();
    capture(32'h00000202); cyc();
    capture(32'h00000303);
    check("abc_count", 32'(count_o), 32'd3);
    ticks(8);
    check("abc_live", 32'(live_o), 32'd1);
    time_i = 32'h00007777;
    recall();
    check("rc1_time", time_o, 32'h00000303);
    check("rc1_lap",  32'(lap_idx_o), 32'd1);
    recall();
    check("rc2_time", time_o, 32'h00000202);
    check("rc2_lap",  32'(lap_idx_o), 32'd2);
    recall();
    check("rc3_time", time_o, 32'h00000101);
    check("rc3_lap",  32'(lap_idx_o), 32'd3);
    recall();
    check("rc4_lap",  32'(lap_idx_o), 32'd0);
    check("rc4_live", 32'(live_o), 32'd1);
    check("rc4_time", time_o, 32'h00007777);

    // Recall out of HOLD jumps to lap 2; recall times out after 8 ticks.
    capture(32'h00000404);
    recall();
    check("hrc_lap",  32'(lap_idx_o), 32'd2);
    check("hrc_time", time_o, 32'h00000303);
    ticks(7);
    check("rto7_live", 32'(live_o), 32'd0);
    ticks(1);
    check("rto8_live", 32'(live_o), 32'd1);

    // DEPTH+1 back-to-back captures.
    clear_i = 1'b1; cyc(); clear_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      time_i = 32'h10 + 32'(k); capture_i = 1'b1; cyc();
    end
    capture_i = 1'b0;
    check("fill_count", 32'(count_o), 32'd8);
    check("fill_full",  32'(full_o), 32'd1);
    capture(32'h00000019);
`ifdef LAP_BUFFER_OVERWRITE_EN
    exp_newest = 32'h00000019; exp_oldest = 32'h00000012;
`else
    exp_newest = 32'h00000018; exp_oldest = 32'h00000011;
`endif
    check("ovf_count", 32'(count_o), 32'd8);
    check("ovf_full",  32'(full_o), 32'd1);
    check("ovf_time",  time_o, exp_newest);
    check("ovf_lap",   32'(lap_idx_o), 32'd1);
    for (int i = 0; i < 7; i++) recall();
    check("old_lap",  32'(lap_idx_o), 32'd8);
    check("old_time", time_o, exp_oldest);
    recall();
    check("old_exit", 32'(live_o), 32'd1);

    // Clear wins over a simultaneous capture.
    time_i = 32'h00009999; capture_i = 1'b1; clear_i = 1'b1; cyc();
    capture_i = 1'b0; clear_i = 1'b0;
    check("cc_count", 32'(count_o), 32'd0);
    check("cc_live",  32'(live_o), 32'd1);
    check("cc_full",  32'(full_o), 32'd0);
    check("cc_time",  time_o, 32'h00009999);

    // Recall on an empty buffer is ignored.
    recall();
    check("empty_live", 32'(live_o), 32'd1);
    check("empty_lap",  32'(lap_idx_o), 32'd0);

    // Reset in the middle of RECALL.
    capture(32'h00000505);
    recall();
    check("pre_rst_lap",  32'(lap_idx_o), 32'd1);
    check("pre_rst_live", 32'(live_o), 32'd0);
    rst = 1'b1; cyc();
    check("mid_rst_time",  time_o, 32'h0);
    check("mid_rst_lap",   32'(lap_idx_o), 32'd0);
    check("mid_rst_count", 32'(count_o), 32'd0);
    check("mid_rst_live",  32'(live_o), 32'd1);
    check("mid_rst_full",  32'(full_o), 32'd0);
    rst = 1'b0; cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lap_buffer.md
# lap_buffer

Split-time capture and recall stage for the stopwatch datapath. Sits between the BCD time counter, which produces eight BCD digits, and the display manager and 7-segment driver, which consume them. On each split pulse from the control FSM it stores the current time in a small circular memory and holds it on the display for a fixed interval. The user can then step back through stored laps before the display returns to the live time.

## Interface
Parameters:
- DEPTH, 8 — number of stored laps; power of two, 2..16.
- HOLD_TICKS, 8 — tick_i pulses a captured split stays on display (250 ms ticks → 2 s).

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  reset; synchronous, active-high.
- tick_i  in  1  single-cycle enable from the 250 ms clock generator.
- capture_i  in  1  single-cycle split pulse from the FSM; clean, debounced.
- recall_i  in  1  single-cycle pulse; step to the next-older stored lap.
- clear_i  in  1  single-cycle pulse; empty the buffer.
- time_i  in  32  live time as {HOUR1,HOUR0,MIN1,MIN0,SEG1,SEG0,CSEG1,CSEG0}, 4-bit BCD each.
- time_o  out  32  digits to display, same packing.
- lap_idx_o  out  4  lap number shown; 0 when live, 1 = most recent.
- count_o  out  5  number of valid entries, 0..DEPTH.
- live_o  out  1  1 when time_o follows time_i.
- full_o  out  1  count_o == DEPTH.

## Operation
- Storage: DEPTH × 32 register array; write pointer wp (log2 DEPTH bits) wraps modulo DEPTH; count saturates at DEPTH.
- The state machine has three states: LIVE, HOLD, RECALL.
- LIVE:
  - time_o = time_i, registered, one cycle late.
  - capture_i → write time_i at wp, wp+1, count+1, load hold counter with HOLD_TICKS, go to HOLD.
  - recall_i with count>0 → RECALL, lap 1.
  - recall_i with count==0 → ignored.
- HOLD:
  - time_o = entry just written; lap_idx_o = 1.
  - Hold counter decrements on each tick_i; reaching 0 → LIVE.
  - capture_i → store again and reload the counter; stay in HOLD.
  - recall_i → RECALL, lap 2 if count≥2, otherwise lap 1.
- RECALL:
  - time_o = entry (wp − lap_idx) mod DEPTH.
  - recall_i advances lap_idx; past count → LIVE, lap_idx 0.
  - capture_i → store, go to HOLD.
  - HOLD_TICKS ticks with no recall_i → LIVE.
- clear_i, any state: count=0, wp=0, go to LIVE. Array contents are not cleared.
- Simultaneous inputs, priority clear_i > capture_i > recall_i; the lower-priority pulse is dropped.
- Full buffer: see Configuration.

## Timing
- Reset values: time_o=0, lap_idx_o=0, count_o=0, live_o=1, full_o=0, state LIVE, wp=0, hold counter 0.
- All outputs are registered.
- capture_i at cycle N:
  - Array entry, count_o and state are updated at N+1.
  - time_o shows the captured value at N+1, equal to time_i sampled at N.
- recall_i at N → new time_o and lap_idx_o at N+1.
- A tick_i in the same cycle as a capture reload is ignored for decrement.
- Reset asserted mid-HOLD or mid-RECALL → all reset values on the next edge.

## Configuration
- LAP_BUFFER_OVERWRITE_EN defined:
  - When full, capture_i overwrites the oldest entry; count stays DEPTH; wp advances.
- Not defined:
  - When full, capture_i is refused: no write, wp and count unchanged.
  - State still goes to HOLD, showing the existing most recent lap.
- full_o behaves identically in both builds.

## Structure
- Shared package stopwatch_pkg:
  - typedef bcd_time_t (packed struct of eight 4-bit digits);
  - enum lap_state_e {LIVE, HOLD, RECALL};
  - constant for the default HOLD_TICKS.
- One sub-module, lap_mem: DEPTH×32 register file with one write port and one combinational read port. Read address computed in lap_buffer.

## Test plan
- Reset, then time_i=0x00012345 → time_o=0x00012345 one cycle later, live_o=1, count_o=0.
- capture at time_i=0x00001050 → time_o=0x00001050, lap_idx_o=1, count_o=1; after 8 tick_i → live_o=1.
- Capture 3 laps A,B,C, then 4× recall_i → shows C,B,A, then live (lap_idx_o 1,2,3,0).
- DEPTH+1 captures:
  - with the macro: count_o=8, oldest lap = capture #2;
  - without: count_o=8, full_o=1, oldest = capture #1.
- capture_i and clear_i in the same cycle → count_o=0, live_o=1, nothing stored.
- recall_i with an empty buffer → stays live, lap_idx_o=0; reset during RECALL → all reset values.
